// File: rtl/id_instr_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : id_instr_queue_if
// Brief   : Enqueue/dequeue/flush bundle between IF, the instruction queue and ID.
// Revision: 1.0  initial release
// ============================================================================
interface id_instr_queue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               enq_valid;
  logic               enq_ready;
  logic [INSTR_W-1:0] enq_instr;
  logic [PC_W-1:0]    enq_pc;
  logic [EXC_W-1:0]   enq_exc;
  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [PC_W-1:0]    deq_pc;
  logic [PC_W-1:0]    deq_pc_plus_4;
  logic [EXC_W-1:0]   deq_exc;
  logic               flush;
  logic               flush_keep;
  logic [CNT_W-1:0]   count;

  // The queue itself.
  modport slave (
    input  enq_valid, enq_instr, enq_pc, enq_exc, deq_ready, flush, flush_keep,
    output enq_ready, deq_valid, deq_instr, deq_pc, deq_pc_plus_4, deq_exc, count
  );

  // The fetch/decode environment around the queue.
  modport master (
    output enq_valid, enq_instr, enq_pc, enq_exc, deq_ready, flush, flush_keep,
    input  enq_ready, deq_valid, deq_instr, deq_pc, deq_pc_plus_4, deq_exc, count
  );
endinterface
`default_nettype wire

// File: rtl/id_instr_queue.sv
`default_nettype none
// ============================================================================
// Module  : id_instr_queue
// Brief   : Circular instruction queue decoupling fetch from decode, with
//           branch flush and optional delay-slot retention.
// Revision: 1.0  initial release
// ============================================================================
module id_instr_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  id_instr_queue_if.slave   q_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = EXC_W + PC_W + INSTR_W;

  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Wrap by compare so non-power-of-two depths index only valid slots.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_enq_ready;
  logic             w_deq_valid;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [PTR_W-1:0] w_rd_next;
  logic             w_survivor;
  logic [ENT_W-1:0] w_head;

  assign w_enq_ready = (r_count < c_cnt_full);
  assign w_deq_valid = (r_count != '0);
  assign w_enq_fire  = q_if.enq_valid & w_enq_ready;
  assign w_deq_fire  = q_if.deq_ready & w_deq_valid;
  assign w_rd_next   = w_deq_fire ? f_inc(r_rd_ptr) : r_rd_ptr;
  // At least one stored entry remains after this cycle's dequeue.
  assign w_survivor  = (r_count != {{(CNT_W-1){1'b0}}, w_deq_fire});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (q_if.flush) begin
      if (!q_if.flush_keep) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        // With no survivor, w_rd_next equals r_wr_ptr, which is exactly
        // where a same-cycle enqueue lands, so one rule covers both cases.
        r_rd_ptr <= w_rd_next;
        if (w_survivor || w_enq_fire) begin
          r_wr_ptr <= f_inc(w_rd_next);
          r_count  <= c_cnt_one;
        end else begin
          r_wr_ptr <= w_rd_next;
          r_count  <= '0;
        end
      end
    end else begin
      if (w_enq_fire) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_deq_fire) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq_fire && w_deq_fire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_wr_ptr] <= {q_if.enq_exc, q_if.enq_pc, q_if.enq_instr};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign q_if.enq_ready     = w_enq_ready;
  assign q_if.deq_valid     = w_deq_valid;
  assign q_if.count         = r_count;
  assign q_if.deq_instr     = w_deq_valid ? w_head[INSTR_W-1:0] : '0;
  assign q_if.deq_pc        = w_deq_valid ? w_head[INSTR_W+PC_W-1:INSTR_W] : '0;
  assign q_if.deq_exc       = w_deq_valid ? w_head[ENT_W-1:INSTR_W+PC_W] : '0;
  assign q_if.deq_pc_plus_4 = q_if.deq_pc + PC_W'(4);

endmodule
`default_nettype wire

// File: tb/tb_id_instr_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_instr_queue
// Brief   : Self-checking bench: DEPTH=4 and DEPTH=3 queues driven in lockstep
//           against a queue-based reference model, plus directed vectors.
// Revision: 1.0  initial release
// ============================================================================
module tb_id_instr_queue;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  exc;
  } ent_t;
  typedef ent_t entq_t[$];

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic [1:0]  exc;
    logic        dr;
    logic        fl;
    logic        fk;
    int          ecnt;
    logic        evld;
    logic [31:0] epc;
    logic [1:0]  eexc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  entq_t q4;
  entq_t q3;

  always #5 clk = ~clk;

  id_instr_queue_if #(.DEPTH(4)) bus4 ();
  id_instr_queue_if #(.DEPTH(3)) bus3 ();

  id_instr_queue #(.DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .q_if(bus4));
  id_instr_queue #(.DEPTH(3)) u_dut3 (.clk(clk), .rst(rst), .q_if(bus3));

  // Reference: queue semantics straight from the behavioural rules.
  function automatic entq_t model_next(entq_t q, int depth, logic ev, ent_t e,
                                       logic dr, logic fl, logic fk);
    entq_t r = q;
    logic  enq_ok = ev && (r.size() < depth);
    logic  deq_ok = dr && (r.size() != 0);
    if (deq_ok) void'(r.pop_front());
    if (fl) begin
      if (!fk) r.delete();
      else if (r.size() > 0) begin
        ent_t h = r[0];
        r.delete();
        r.push_back(h);
      end else if (enq_ok) r.push_back(e);
    end else if (enq_ok) begin
      r.push_back(e);
    end
    return r;
  endfunction

  task automatic check_q(input string nm, input entq_t q, input int depth,
                         input int a_cnt, input logic a_rdy, input logic a_vld,
                         input logic [31:0] a_ins, input logic [31:0] a_pc,
                         input logic [31:0] a_p4, input logic [1:0] a_exc);
    int          e_cnt = q.size();
    logic        e_vld = (q.size() != 0);
    logic        e_rdy = (q.size() < depth);
    logic [31:0] e_ins = e_vld ? q[0].instr : 32'h0;
    logic [31:0] e_pc  = e_vld ? q[0].pc : 32'h0;
    logic [1:0]  e_exc = e_vld ? q[0].exc : 2'b00;
    logic [31:0] e_p4  = e_pc + 32'd4;
    n_cmp++;
    if (a_cnt != e_cnt || a_rdy !== e_rdy || a_vld !== e_vld || a_ins !== e_ins ||
        a_pc !== e_pc || a_p4 !== e_p4 || a_exc !== e_exc) begin
      n_bad++;
      $display("FAIL %s t=%0t: got cnt=%0d rdy=%b vld=%b ins=%h pc=%h p4=%h exc=%b, want cnt=%0d rdy=%b vld=%b ins=%h pc=%h p4=%h exc=%b",
               nm, $time, a_cnt, a_rdy, a_vld, a_ins, a_pc, a_p4, a_exc,
               e_cnt, e_rdy, e_vld, e_ins, e_pc, e_p4, e_exc);
    end
  endtask

  task automatic check_both(input string nm);
    check_q({nm, "/d4"}, q4, 4, int'(bus4.count), bus4.enq_ready, bus4.deq_valid,
            bus4.deq_instr, bus4.deq_pc, bus4.deq_pc_plus_4, bus4.deq_exc);
    check_q({nm, "/d3"}, q3, 3, int'(bus3.count), bus3.enq_ready, bus3.deq_valid,
            bus3.deq_instr, bus3.deq_pc, bus3.deq_pc_plus_4, bus3.deq_exc);
  endtask

  task automatic set_inputs(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [1:0] exc, input logic dr, input logic fl,
                            input logic fk);
    bus4.enq_valid = ev; bus4.enq_instr = ins; bus4.enq_pc = pc; bus4.enq_exc = exc;
    bus4.deq_ready = dr; bus4.flush = fl; bus4.flush_keep = fk;
    bus3.enq_valid = ev; bus3.enq_instr = ins; bus3.enq_pc = pc; bus3.enq_exc = exc;
    bus3.deq_ready = dr; bus3.flush = fl; bus3.flush_keep = fk;
  endtask

  // One clock: apply inputs, advance the model, clock, compare both DUTs.
  task automatic step(input string nm, input logic ev, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [1:0] exc,
                      input logic dr, input logic fl, input logic fk);
    ent_t e;
    e.instr = ins; e.pc = pc; e.exc = exc;
    set_inputs(ev, ins, pc, exc, dr, fl, fk);
    q4 = model_next(q4, 4, ev, e, dr, fl, fk);
    q3 = model_next(q3, 3, ev, e, dr, fl, fk);
    @(posedge clk);
    #1;
    check_both(nm);
  endtask

  vec_t vt[$];

  function automatic vec_t mk(logic ev, logic [31:0] pc, logic [1:0] exc, logic dr,
                              logic fl, logic fk, int ecnt, logic evld,
                              logic [31:0] epc, logic [1:0] eexc);
    vec_t v;
    v.ev = ev; v.pc = pc; v.exc = exc; v.dr = dr; v.fl = fl; v.fk = fk;
    v.ecnt = ecnt; v.evld = evld; v.epc = epc; v.eexc = eexc;
    return v;
  endfunction

  initial begin
    // Directed vectors for the DEPTH=4 instance, starting from an empty queue.
    vt.push_back(mk(1, 32'h100, 2'b00, 0, 0, 0, 1, 1, 32'h100, 2'b00));
    vt.push_back(mk(1, 32'h104, 2'b00, 0, 0, 0, 2, 1, 32'h100, 2'b00));
    vt.push_back(mk(1, 32'h108, 2'b00, 0, 0, 0, 3, 1, 32'h100, 2'b00));
    vt.push_back(mk(1, 32'h10C, 2'b00, 0, 0, 0, 4, 1, 32'h100, 2'b00));
    vt.push_back(mk(1, 32'h110, 2'b00, 0, 0, 0, 4, 1, 32'h100, 2'b00));
    vt.push_back(mk(1, 32'h110, 2'b00, 1, 0, 0, 3, 1, 32'h104, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 2, 1, 32'h108, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 1, 1, 32'h10C, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(1, 32'h200, 2'b00, 0, 0, 0, 1, 1, 32'h200, 2'b00));
    vt.push_back(mk(1, 32'h204, 2'b00, 0, 0, 0, 2, 1, 32'h200, 2'b00));
    vt.push_back(mk(1, 32'h208, 2'b00, 0, 0, 0, 3, 1, 32'h200, 2'b00));
    vt.push_back(mk(1, 32'h20C, 2'b00, 0, 1, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(1, 32'h300, 2'b00, 0, 0, 0, 1, 1, 32'h300, 2'b00));
    vt.push_back(mk(1, 32'h304, 2'b00, 0, 0, 0, 2, 1, 32'h300, 2'b00));
    vt.push_back(mk(1, 32'h308, 2'b00, 0, 0, 0, 3, 1, 32'h300, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 1, 1, 1, 1, 32'h304, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(1, 32'h300, 2'b00, 0, 0, 0, 1, 1, 32'h300, 2'b00));
    vt.push_back(mk(1, 32'h304, 2'b00, 1, 1, 1, 1, 1, 32'h304, 2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 0, 1, 1, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(0, 32'h0,   2'b00, 0, 1, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(1, 32'hBFC0_0001, 2'b01, 0, 0, 0, 1, 1, 32'hBFC0_0001, 2'b01));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));
    vt.push_back(mk(1, 32'hFFFF_FFFC, 2'b10, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 2'b10));
    vt.push_back(mk(0, 32'h0,   2'b00, 1, 0, 0, 0, 0, 32'h0,   2'b00));

    set_inputs(0, 32'h0, 32'h0, 2'b00, 0, 0, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_both("reset");

    rst = 1'b1;
    foreach (vt[i]) begin
      step($sformatf("vec%0d", i), vt[i].ev, vt[i].pc ^ 32'hA5A5_0000, vt[i].pc,
           vt[i].exc, vt[i].dr, vt[i].fl, vt[i].fk);
      n_cmp++;
      if (int'(bus4.count) != vt[i].ecnt || bus4.deq_valid !== vt[i].evld ||
          bus4.deq_pc !== vt[i].epc || bus4.deq_exc !== vt[i].eexc) begin
        n_bad++;
        $display("FAIL table%0d: got cnt=%0d vld=%b pc=%h exc=%b, want cnt=%0d vld=%b pc=%h exc=%b",
                 i, bus4.count, bus4.deq_valid, bus4.deq_pc, bus4.deq_exc,
                 vt[i].ecnt, vt[i].evld, vt[i].epc, vt[i].eexc);
      end
    end

    // DEPTH=3 wrap: steady one-in/one-out holds occupancy at 1.
    step("wrap_fill", 1, 32'h400 ^ 32'hA5A5_0000, 32'h400, 2'b00, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      logic [31:0] pc = 32'h400 + 32'(4 * i);
      step($sformatf("wrap%0d", i), 1, pc ^ 32'hA5A5_0000, pc, 2'b00, 1, 0, 0);
      n_cmp++;
      if (int'(bus3.count) != 1 || bus3.deq_pc !== pc) begin
        n_bad++;
        $display("FAIL wrap%0d: got cnt=%0d pc=%h, want cnt=1 pc=%h",
                 i, bus3.count, bus3.deq_pc, pc);
      end
    end
    step("wrap_drain", 0, 32'h0, 32'h0, 2'b00, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc  = $urandom;
      logic [31:0] ins = $urandom;
      logic [1:0]  exc = 2'($urandom_range(0, 3));
      logic        ev  = ($urandom_range(0, 3) != 0);
      logic        dr  = ($urandom_range(0, 1) != 0);
      logic        fl  = ($urandom_range(0, 15) == 0);
      logic        fk  = ($urandom_range(0, 1) != 0);
      step("rand", ev, ins, pc, exc, dr, fl, fk);
    end

    // Asynchronous reset in the middle of a cycle, with entries queued.
    step("pre_rst_a", 1, 32'h1111_1111, 32'h600, 2'b00, 0, 0, 0);
    step("pre_rst_b", 1, 32'h2222_2222, 32'h604, 2'b00, 0, 0, 0);
    set_inputs(0, 32'h0, 32'h0, 2'b00, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    q4.delete();
    q3.delete();
    check_both("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_rst", 1, 32'h3333_3333, 32'h500, 2'b00, 0, 0, 0);
    n_cmp++;
    if (int'(bus4.count) != 1 || bus4.deq_pc !== 32'h500) begin
      n_bad++;
      $display("FAIL post_rst_first: got cnt=%0d pc=%h, want cnt=1 pc=00000500",
               bus4.count, bus4.deq_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
